calc_op_sequencer: RTL and testbench
====================================

// Module: calc_op_sequencer
// PURPOSE
//   Multi-cycle operation controller for the calculator datapath. It time-shares one external
//   N-bit carry-lookahead adder (combinational, Sum = A + B + cin, no carry-out) and sequences it
//   to perform ADD, SUB (two's complement) and truncated shift-and-add MUL.
//   Sits between the calculator front end (start/op/operands) and the adder instance.
// PARAMETERS
//   N  4  operand / result / adder width in bits (N >= 2)
// PORTS
//   clk        in   1         system clock, all state updates on rising edge
//   rst_n      in   1         asynchronous, active-low reset
//   start      in   1         request; sampled only in IDLE
//   op         in   2         00 ADD, 01 SUB, 10 MUL, 11 reserved (error)
//   a          in   N         operand A, sampled with accepted start
//   b          in   N         operand B, sampled with accepted start
//   busy       out  1         high from cycle after accepted start until done cycle inclusive
//   done       out  1         one-cycle pulse: result/err valid
//   result     out  N         registered result, held until next completion
//   err        out  1         1 = last op was reserved; held like result
//   add_a      out  N         to adder A
//   add_b      out  N         to adder B
//   add_cin    out  1         to adder cin
//   add_sum    in   N         from adder Sum (combinational, same-cycle use)
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE; busy, done, err, add_cin = 0; result, add_a, add_b, cnt, acc = 0.
//   - States: IDLE, EXEC (ADD/SUB/ERR), MUL, DONE.
//   - IDLE: add_a/add_b/add_cin driven 0. start=1 at edge: latch a_r=a, b_r=b, op_r=op;
//     op 00/01/11 -> EXEC; op 10 -> MUL with acc=0, cnt=0.
//   - EXEC (1 cycle): ADD drives add_a=a_r, add_b=b_r, cin=0; SUB drives add_b=~b_r, cin=1.
//     Exit edge: result=add_sum, err=0 -> DONE. Op 11: adder driven 0; result=0, err=1 -> DONE.
//   - MUL (exactly N cycles, cnt 0..N-1): add_a=acc, add_b=(a_r<<cnt) truncated to N bits, cin=0.
//     Each edge: acc = b_r[cnt] ? add_sum : acc; cnt++. When cnt==N-1: result = final acc, err=0 -> DONE.
//   - DONE (1 cycle): done=1, busy=1, adder inputs 0; next edge -> IDLE.
//   - Latency from start edge to done cycle: ADD/SUB/ERR 2 cycles, MUL N+1 cycles.
//     Back-to-back: start may be accepted on the edge leaving DONE? No - only in IDLE, so min issue
//     interval = latency+1.
//   - start while not IDLE is ignored (not queued); a/b/op changes while busy have no effect.
//   - Arithmetic modulo 2^N: overflow/borrow silently wrap; MUL returns low N bits of product.
//   - result/err change only on the edge entering DONE (or on reset).
//   - Reset mid-operation aborts: no done pulse; result and err return to 0.
// TESTING (N=4)
//   1. ADD a=5,b=9 -> done 2 cycles after start, result=0xE, err=0; a=9,b=9 -> result=0x2.
//   2. SUB a=3,b=7 -> result=0xC (add_b=0x8, add_cin=1 seen in EXEC); a=7,b=3 -> result=0x4.
//   3. MUL a=3,b=5 -> done N+1=5 cycles after start, result=0xF; a=7,b=6 -> result=0xA; b=0 -> result=0x0.
//   4. op=11 a=1,b=1 -> done 2 cycles after start, err=1, result=0; next ADD 1+1 -> err=0, result=2.
//   5. start pulsed every cycle during a MUL -> only first accepted; exactly one done; result from
//      first operands.
//   6. rst_n low mid-MUL (cnt=2) -> busy, done, result, err, add_* = 0 immediately; new start after
//      release completes normally.

Source files
------------

// File: rtl/calc_op_sequencer_if.sv
// Bundles the calculator front-end handshake and the shared-adder bus.
// slave is the sequencer's view; master is the front end plus adder.
interface calc_op_sequencer_if #(
   parameter int N = 4
);
   logic         start;
   logic [1:0]   op;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         err;
   logic [N-1:0] add_a;
   logic [N-1:0] add_b;
   logic         add_cin;
   logic [N-1:0] add_sum;

   modport master (
      output start, op, a, b, add_sum,
      input  busy, done, result, err, add_a, add_b, add_cin
   );

   modport slave (
      input  start, op, a, b, add_sum,
      output busy, done, result, err, add_a, add_b, add_cin
   );
endinterface

// File: rtl/calc_op_sequencer.sv
// Multi-cycle ADD/SUB/MUL controller that time-shares one external N-bit adder
// (Sum = A + B + cin); MUL is a truncated shift-and-add over N cycles.
module calc_op_sequencer #(
   parameter int N = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   calc_op_sequencer_if.slave  seq
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_MUL,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_RSV = 2'b11
   } op_t;

   state_t        state;
   state_t        state_nxt;
   op_t           op_r;
   logic [N-1:0]  a_r;
   logic [N-1:0]  b_r;
   logic [N-1:0]  acc;
   logic [N-1:0]  acc_nxt;
   logic [CW-1:0] cnt;
   logic [N-1:0]  result_r;
   logic          err_r;
   logic [N-1:0]  add_a_c;
   logic [N-1:0]  add_b_c;
   logic          add_cin_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      add_a_c   = '0;
      add_b_c   = '0;
      add_cin_c = 1'b0;
      acc_nxt   = acc;
      case (state)
         S_IDLE: begin
            if (seq.start) begin
               state_nxt = (op_t'(seq.op) == OP_MUL) ? S_MUL : S_EXEC;
            end
         end
         S_EXEC: begin
            state_nxt = S_DONE;
            case (op_r)
               OP_ADD: begin
                  add_a_c = a_r;
                  add_b_c = b_r;
               end
               OP_SUB: begin
                  add_a_c   = a_r;
                  add_b_c   = ~b_r;
                  add_cin_c = 1'b1;
               end
               default: begin
                  add_a_c = '0;
               end
            endcase
         end
         S_MUL: begin
            add_a_c = acc;
            add_b_c = a_r << cnt;
            acc_nxt = b_r[cnt] ? seq.add_sum : acc;
            if (cnt == CNT_LAST) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Operands are captured only on an accepted start; later changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r     <= OP_ADD;
         a_r      <= '0;
         b_r      <= '0;
         acc      <= '0;
         cnt      <= '0;
         result_r <= '0;
         err_r    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (seq.start) begin
                  op_r <= op_t'(seq.op);
                  a_r  <= seq.a;
                  b_r  <= seq.b;
                  acc  <= '0;
                  cnt  <= '0;
               end
            end
            S_EXEC: begin
               if (op_r == OP_RSV) begin
                  result_r <= '0;
                  err_r    <= 1'b1;
               end else begin
                  result_r <= seq.add_sum;
                  err_r    <= 1'b0;
               end
            end
            S_MUL: begin
               acc <= acc_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  result_r <= acc_nxt;
                  err_r    <= 1'b0;
               end
            end
            default: begin
               acc <= acc;
            end
         endcase
      end
   end

   assign seq.busy    = (state != S_IDLE);
   assign seq.done    = (state == S_DONE);
   assign seq.result  = result_r;
   assign seq.err     = err_r;
   assign seq.add_a   = add_a_c;
   assign seq.add_b   = add_b_c;
   assign seq.add_cin = add_cin_c;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer at N=4 with a behavioural adder on the
// adder bus; expected values are hand-computed constants.
module tb_calc_op_sequencer;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   calc_op_sequencer_if #(.N(N)) ifc ();

   assign ifc.add_sum = N'(ifc.add_a + ifc.add_b + {{(N-1){1'b0}}, ifc.add_cin});

   calc_op_sequencer #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .seq   (ifc.slave)
   );

   // Waits for IDLE, issues one op, and reports what was seen; no checking here.
   task automatic issue(input logic [1:0] opv, input logic [3:0] av, input logic [3:0] bv,
                        output int lat, output logic [3:0] res, output logic e,
                        output logic busy1, output logic [3:0] pb, output logic pc,
                        output logic to);
      int guard;
      guard = 0;
      @(negedge clk);
      while (ifc.busy && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      ifc.start = 1'b1;
      ifc.op    = opv;
      ifc.a     = av;
      ifc.b     = bv;
      @(posedge clk);
      #1;
      ifc.start = 1'b0;
      busy1 = ifc.busy;
      pb    = ifc.add_b;
      pc    = ifc.add_cin;
      lat   = 1;
      while (!ifc.done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      to  = !ifc.done;
      res = ifc.result;
      e   = ifc.err;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({ifc.busy, ifc.done, ifc.err, ifc.add_cin, ifc.result, ifc.add_a, ifc.add_b} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got busy=%b done=%b err=%b cin=%b result=%h add_a=%h add_b=%h, want all 0",
                  ifc.busy, ifc.done, ifc.err, ifc.add_cin, ifc.result, ifc.add_a, ifc.add_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      int lat; logic [3:0] res, pb; logic e, b1, pc, to;
      issue(2'b00, 4'd5, 4'd9, lat, res, e, b1, pb, pc, to);
      total++;
      if (to !== 1'b0 || lat !== 2) begin
         bad++; $display("FAIL add_latency: got %0d (timeout=%b), want 2", lat, to);
      end
      total++;
      if (b1 !== 1'b1) begin
         bad++; $display("FAIL add_busy: got %b, want 1", b1);
      end
      total++;
      if (res !== 4'hE || e !== 1'b0) begin
         bad++; $display("FAIL add_5_9: got result=%h err=%b, want E/0", res, e);
      end
      issue(2'b00, 4'd9, 4'd9, lat, res, e, b1, pb, pc, to);
      total++;
      if (to !== 1'b0 || res !== 4'h2 || e !== 1'b0) begin
         bad++; $display("FAIL add_9_9_wrap: got result=%h err=%b timeout=%b, want 2/0/0", res, e, to);
      end
   endtask

   task automatic test_sub();
      int lat; logic [3:0] res, pb; logic e, b1, pc, to;
      issue(2'b01, 4'd3, 4'd7, lat, res, e, b1, pb, pc, to);
      total++;
      if (pb !== 4'h8 || pc !== 1'b1) begin
         bad++; $display("FAIL sub_adder_inputs: got add_b=%h cin=%b, want 8/1", pb, pc);
      end
      total++;
      if (to !== 1'b0 || lat !== 2 || res !== 4'hC || e !== 1'b0) begin
         bad++; $display("FAIL sub_3_7: got result=%h err=%b lat=%0d, want C/0/2", res, e, lat);
      end
      issue(2'b01, 4'd7, 4'd3, lat, res, e, b1, pb, pc, to);
      total++;
      if (to !== 1'b0 || res !== 4'h4 || e !== 1'b0) begin
         bad++; $display("FAIL sub_7_3: got result=%h err=%b, want 4/0", res, e);
      end
   endtask

   task automatic test_mul();
      int lat; logic [3:0] res, pb; logic e, b1, pc, to;
      issue(2'b10, 4'd3, 4'd5, lat, res, e, b1, pb, pc, to);
      total++;
      if (to !== 1'b0 || lat !== 5) begin
         bad++; $display("FAIL mul_latency: got %0d (timeout=%b), want 5", lat, to);
      end
      total++;
      if (res !== 4'hF || e !== 1'b0) begin
         bad++; $display("FAIL mul_3_5: got result=%h err=%b, want F/0", res, e);
      end
      issue(2'b10, 4'd7, 4'd6, lat, res, e, b1, pb, pc, to);
      total++;
      if (to !== 1'b0 || res !== 4'hA || e !== 1'b0) begin
         bad++; $display("FAIL mul_7_6_trunc: got result=%h err=%b, want A/0", res, e);
      end
      issue(2'b10, 4'd9, 4'd0, lat, res, e, b1, pb, pc, to);
      total++;
      if (to !== 1'b0 || res !== 4'h0 || lat !== 5) begin
         bad++; $display("FAIL mul_b0: got result=%h lat=%0d, want 0/5", res, lat);
      end
   endtask

   task automatic test_err();
      int lat; logic [3:0] res, pb; logic e, b1, pc, to;
      issue(2'b11, 4'd1, 4'd1, lat, res, e, b1, pb, pc, to);
      total++;
      if (to !== 1'b0 || lat !== 2 || res !== 4'h0 || e !== 1'b1) begin
         bad++; $display("FAIL reserved_op: got result=%h err=%b lat=%0d, want 0/1/2", res, e, lat);
      end
      total++;
      if (pb !== 4'h0 || pc !== 1'b0) begin
         bad++; $display("FAIL reserved_adder_idle: got add_b=%h cin=%b, want 0/0", pb, pc);
      end
      issue(2'b00, 4'd1, 4'd1, lat, res, e, b1, pb, pc, to);
      total++;
      if (to !== 1'b0 || res !== 4'h2 || e !== 1'b0) begin
         bad++; $display("FAIL add_after_err: got result=%h err=%b, want 2/0", res, e);
      end
   endtask

   task automatic test_hold();
      ifc.a  = 4'hF;
      ifc.b  = 4'hF;
      ifc.op = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (ifc.result !== 4'h2 || ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
         bad++; $display("FAIL result_hold: got result=%h done=%b busy=%b, want 2/0/0",
                         ifc.result, ifc.done, ifc.busy);
      end
   endtask

   task automatic test_back_to_back();
      int ndone, cyc, first_lat;
      logic [3:0] res;
      ndone = 0;
      first_lat = 0;
      res = 4'h0;
      @(negedge clk);
      ifc.start = 1'b1;
      ifc.op    = 2'b10;
      ifc.a     = 4'd3;
      ifc.b     = 4'd5;
      @(posedge clk);
      #1;
      ifc.op = 2'b00;
      ifc.a  = 4'd7;
      ifc.b  = 4'd6;
      for (cyc = 2; cyc < 14; cyc++) begin
         @(posedge clk);
         #1;
         if (ifc.done) begin
            ndone++;
            if (ndone == 1) begin
               first_lat = cyc;
               res = ifc.result;
            end
            ifc.start = 1'b0;
         end
      end
      ifc.start = 1'b0;
      total++;
      if (ndone !== 1) begin
         bad++; $display("FAIL b2b_done_count: got %0d, want 1", ndone);
      end
      total++;
      if (res !== 4'hF || first_lat !== 5) begin
         bad++; $display("FAIL b2b_result: got result=%h lat=%0d, want F/5", res, first_lat);
      end
   endtask

   task automatic test_reset_mid_mul();
      int lat, ndone; logic [3:0] res, pb; logic e, b1, pc, to;
      @(negedge clk);
      ifc.start = 1'b1;
      ifc.op    = 2'b10;
      ifc.a     = 4'd3;
      ifc.b     = 4'd5;
      @(posedge clk);
      #1;
      ifc.start = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      total++;
      if (ifc.busy !== 1'b1 || ifc.add_b !== 4'hC) begin
         bad++; $display("FAIL mid_mul_state: got busy=%b add_b=%h, want 1/C", ifc.busy, ifc.add_b);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({ifc.busy, ifc.done, ifc.err, ifc.add_cin, ifc.result, ifc.add_a, ifc.add_b} !== '0) begin
         bad++;
         $display("FAIL reset_abort: got busy=%b done=%b err=%b cin=%b result=%h add_a=%h add_b=%h, want all 0",
                  ifc.busy, ifc.done, ifc.err, ifc.add_cin, ifc.result, ifc.add_a, ifc.add_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (ifc.done || ifc.busy) ndone++;
      end
      total++;
      if (ndone !== 0) begin
         bad++; $display("FAIL reset_no_done: got %0d active cycles, want 0", ndone);
      end
      issue(2'b00, 4'd1, 4'd1, lat, res, e, b1, pb, pc, to);
      total++;
      if (to !== 1'b0 || lat !== 2 || res !== 4'h2 || e !== 1'b0) begin
         bad++; $display("FAIL post_reset_add: got result=%h err=%b lat=%0d, want 2/0/2", res, e, lat);
      end
   endtask

   initial begin
      ifc.start = 1'b0;
      ifc.op    = 2'b00;
      ifc.a     = '0;
      ifc.b     = '0;
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_err();
      test_hold();
      test_back_to_back();
      test_reset_mid_mul();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
